mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: an EX result is presented this cycle.
REQ-004 SHALL have port aluout, input, 32 bits: ALU result, which is the effective address for loads and stores.
REQ-005 SHALL have port rs2data, input, 32 bits: store source data.
REQ-006 SHALL have ports opcode (input, 7 bits) and funct3 (input, 3 bits): instruction decode fields.
REQ-007 SHALL have ports rd (input, 5 bits) and regwrite (input, 1 bit): destination register and write enable.
REQ-008 SHALL have port stall, output, 1 bit: upstream must hold its inputs while this is high.
REQ-009 SHALL have ports dmem_req (output, 1 bit), dmem_we (output, 1 bit), dmem_addr (output, 32 bits, word-aligned), dmem_be (output, 4 bits), dmem_wdata (output, 32 bits): data memory request.
REQ-010 SHALL have ports dmem_ready (input, 1 bit) and dmem_rdata (input, 32 bits): data memory completion and read word.
REQ-011 SHALL have ports wb_valid (output, 1 bit), wb_rd (output, 5 bits), wb_regwrite (output, 1 bit), wb_data (output, 32 bits), wb_exc (output, 1 bit): registered MEM/WB outputs.

Function
REQ-012 SHALL accept an input when in_valid=1 and stall=0.
REQ-013 SHALL implement states IDLE and REQ, with stall=1 exactly when the state is REQ.
REQ-014 SHALL, for an accepted non-memory opcode (neither 0000011 nor 0100011), produce wb_valid=1, wb_data=aluout, wb_rd=rd and wb_regwrite=regwrite on the next cycle, and stay in IDLE.
REQ-015 SHALL, for an accepted legal and aligned load or store, latch the operands and move to REQ.
REQ-016 SHALL, in REQ, hold dmem_req=1 with stable address, be, we and wdata until a cycle with dmem_ready=1, then return to IDLE.
REQ-017 SHALL give the load/store timeline as: accept at cycle N; dmem_req from N+1; if dmem_ready arrives at cycle M (M>=N+1), wb_valid=1 at M+1.
REQ-018 SHALL drive dmem_addr={aluout[31:2],2'b00} and dmem_we=1 for stores, 0 for loads.
REQ-019 SHALL drive dmem_be for sb as 4'b0001<<addr[1:0], for sh as 0011 when addr[1]=0 and 1100 otherwise, and for sw as 1111; loads use 1111.
REQ-020 SHALL drive dmem_wdata for sb as {4{rs2data[7:0]}}, for sh as {2{rs2data[15:0]}}, and for sw as rs2data.
REQ-021 SHALL form load results from the addressed byte or halfword: lb and lh sign-extend, lbu and lhu zero-extend, lw passes the word through.
REQ-022 SHALL write back stores with wb_valid=1, wb_regwrite=0 and wb_data=0.
REQ-023 SHALL treat halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as misaligned.
REQ-024 SHALL treat load funct3 011/110/111 and store funct3 >=011 as illegal.
REQ-025 SHALL, for a misaligned or illegal access, issue no dmem_req and produce wb_valid=1, wb_exc=1, wb_regwrite=0 on the next cycle.
REQ-026 SHALL keep wb_valid a one-cycle pulse per accepted op; with no accept, wb_valid=0 and the other wb_* outputs hold their values.
REQ-027 SHALL ignore dmem_ready while in IDLE.
REQ-028 SHALL keep stall=1 in the dmem_ready cycle, so back-to-back memory ops are spaced at least 2 cycles apart.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set the state to IDLE and all outputs (stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_rd, wb_regwrite, wb_data, wb_exc) to 0.
REQ-030 SHALL let reset taken while in REQ abandon the outstanding access, with no wb_valid for it.

Structure
REQ-031 SHALL place the opcode constants (0000011, 0100011), funct3 encodings and the state encoding in shared package riscv_pkg.
REQ-032 SHALL implement the byte/halfword extraction and extension of REQ-021 in combinational sub-module load_align (inputs: rdata, addr[1:0], funct3; output: 32-bit data).

Verification
REQ-033 SHALL check: opcode 0110011, aluout=0x00000007, rd=5 -> next cycle wb_valid=1, wb_data=0x00000007, wb_rd=5, no dmem_req.
REQ-034 SHALL check: lb at aluout=0x00000103, dmem_rdata=0x80FF1234, ready 2 cycles after request -> dmem_addr=0x00000100, stall held 2 cycles, wb_data=0xFFFFFF80; the same access as lbu gives 0x00000080.
REQ-035 SHALL check: sh at aluout=0x00000206, rs2data=0xDEADBEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, wb_regwrite=0.
REQ-036 SHALL check: lw at aluout=0x00000102 -> no dmem_req, wb_exc=1, wb_regwrite=0 one cycle later.
REQ-037 SHALL check: rst asserted while in REQ -> next cycle dmem_req=0, stall=0, and no wb_valid ever follows for that op.
REQ-038 SHALL check: sw immediately followed by an ALU op held on the inputs -> the ALU op is accepted the cycle after dmem_ready, and wb_valid appears on two separate cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and MEM-stage helpers.
// Contents: load/store opcodes, load/store funct3 encodings, MEM FSM state
// encoding, and store byte-enable / write-data lane helpers.
package riscv_pkg;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  // funct3 encodings shared by loads and stores (stores use B/H/W only)
  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } mem_state_e;

  // Byte enables for a store of width funct3 at byte offset addr_lo.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3B:     be = 4'b0001 << addr_lo;
      F3H:     be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across all lanes; byte enables pick the lane.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] wdata;
    case (funct3)
      F3B:     wdata = {4{data[7:0]}};
      F3H:     wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load result alignment: selects the addressed byte/halfword of a memory word
// and sign- or zero-extends it according to the load funct3.
// Ports:
//   rdata  - 32-bit word returned by data memory
//   addr   - low two bits of the effective address
//   funct3 - load width / signedness
//   data   - 32-bit register write-back value
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rdata >> {addr, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3B:     data = {{24{byte_sel[7]}}, byte_sel};
      F3Bu:    data = {24'b0, byte_sel};
      F3H:     data = {{16{half_sel[15]}}, half_sel};
      F3Hu:    data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes non-memory results to WB, issues load/store
// requests to data memory with a two-state handshake FSM, aligns load data,
// and flags illegal or misaligned accesses as exceptions.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_valid, aluout, rs2data,
//   opcode, funct3, rd, regwrite - EX result presented to this stage
//   stall                       - upstream must hold its inputs
//   dmem_req/we/addr/be/wdata   - data memory request (held stable in REQ)
//   dmem_ready, dmem_rdata      - data memory completion and read word
//   wb_valid/rd/regwrite/data/exc - registered MEM/WB outputs
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] aluout,
  input  logic [31:0] rs2data,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        regwrite,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic [31:0] wb_data,
  output logic        wb_exc
);

  mem_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_exc_q, wb_exc_d;

  logic        is_load, is_store, legal, misaligned;
  logic [31:0] load_data;

  assign is_load  = (opcode == OpcLoad);
  assign is_store = (opcode == OpcStore);

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      legal = (funct3 == F3B) || (funct3 == F3H) || (funct3 == F3W) ||
              (funct3 == F3Bu) || (funct3 == F3Hu);
    end else if (is_store) begin
      legal = (funct3 == F3B) || (funct3 == F3H) || (funct3 == F3W);
    end
  end

  // funct3[1:0] gives access width for every legal encoding
  assign misaligned = ((funct3[1:0] == 2'b01) && aluout[0]) ||
                      ((funct3[1:0] == 2'b10) && (aluout[1:0] != 2'b00));

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (addr_lo_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    addr_lo_d     = addr_lo_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_data_d     = wb_data_q;
    wb_exc_d      = wb_exc_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          wb_rd_d = rd;
          if (!is_load && !is_store) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = regwrite;
            wb_data_d     = aluout;
            wb_exc_d      = 1'b0;
          end else if (!legal || misaligned) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = 1'b0;
            wb_data_d     = 32'b0;
            wb_exc_d      = 1'b1;
          end else begin
            // wb_rd is re-written at completion; keep it stable until then
            wb_rd_d    = wb_rd_q;
            state_d    = StReq;
            we_d       = is_store;
            addr_d     = {aluout[31:2], 2'b00};
            addr_lo_d  = aluout[1:0];
            f3_d       = funct3;
            rd_d       = rd;
            regwrite_d = regwrite;
            be_d       = is_store ? store_be(funct3, aluout[1:0]) : 4'b1111;
            wdata_d    = is_store ? store_wdata(funct3, rs2data) : 32'b0;
          end
        end
      end
      StReq: begin
        if (dmem_ready) begin
          state_d       = StIdle;
          wb_valid_d    = 1'b1;
          wb_rd_d       = rd_q;
          wb_exc_d      = 1'b0;
          wb_regwrite_d = we_q ? 1'b0 : regwrite_q;
          wb_data_d     = we_q ? 32'b0 : load_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      addr_q        <= 32'b0;
      be_q          <= 4'b0;
      wdata_q       <= 32'b0;
      addr_lo_q     <= 2'b0;
      f3_q          <= 3'b0;
      rd_q          <= 5'b0;
      regwrite_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'b0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= 32'b0;
      wb_exc_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      addr_lo_q     <= addr_lo_d;
      f3_q          <= f3_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_data_q     <= wb_data_d;
      wb_exc_q      <= wb_exc_d;
    end
  end

  assign stall       = (state_q == StReq);
  assign dmem_req    = (state_q == StReq);
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_data     = wb_data_q;
  assign wb_exc      = wb_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of directed single-op vectors plus
// hand-written sequences for reset state, reset during a request, ready while
// idle, and a store followed by a held ALU op.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] aluout, rs2data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        regwrite;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_regwrite, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .aluout      (aluout),
    .rs2data     (rs2data),
    .opcode      (opcode),
    .funct3      (funct3),
    .rd          (rd),
    .regwrite    (regwrite),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .wb_data     (wb_data),
    .wb_exc      (wb_exc)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    int          delay;    // request cycles until ready (mem ops only)
    logic        mem;      // a dmem request is expected
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        exc;
    logic [31:0] wbd;      // checked only when exc=0
    logic        wbrw;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs[NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    aluout     = 32'b0;
    rs2data    = 32'b0;
    opcode     = 7'b0;
    funct3     = 3'b0;
    rd         = 5'b0;
    regwrite   = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    chk($sformatf("v%0d stall_before", idx), 32'(stall), 32'd0);
    in_valid = 1'b1;
    opcode   = v.opcode;
    funct3   = v.f3;
    aluout   = v.alu;
    rs2data  = v.rs2;
    rd       = v.rd;
    regwrite = v.rw;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (v.mem) begin
      for (int k = 1; k <= v.delay; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d req c%0d", idx, k), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d stall c%0d", idx, k), 32'(stall), 32'd1);
        chk($sformatf("v%0d addr c%0d", idx, k), dmem_addr, v.addr);
        chk($sformatf("v%0d be c%0d", idx, k), 32'(dmem_be), 32'(v.be));
        chk($sformatf("v%0d wdata c%0d", idx, k), dmem_wdata, v.wdata);
        chk($sformatf("v%0d we c%0d", idx, k), 32'(dmem_we), 32'(v.we));
        chk($sformatf("v%0d wbv_wait c%0d", idx, k), 32'(wb_valid), 32'd0);
        if (k == v.delay) begin
          dmem_ready = 1'b1;
          dmem_rdata = v.rdata;
        end
        @(posedge clk);
        #1 dmem_ready = 1'b0;
        dmem_rdata = 32'hx;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d req_after", idx), 32'(dmem_req), 32'd0);
    chk($sformatf("v%0d stall_after", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d wb_valid", idx), 32'(wb_valid), 32'd1);
    chk($sformatf("v%0d wb_exc", idx), 32'(wb_exc), 32'(v.exc));
    chk($sformatf("v%0d wb_regwrite", idx), 32'(wb_regwrite), 32'(v.wbrw));
    chk($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
    if (!v.exc) chk($sformatf("v%0d wb_data", idx), wb_data, v.wbd);
    @(negedge clk);
    chk($sformatf("v%0d wb_valid_pulse", idx), 32'(wb_valid), 32'd0);
    chk($sformatf("v%0d wb_rd_hold", idx), 32'(wb_rd), 32'(v.rd));
    if (!v.exc) chk($sformatf("v%0d wb_data_hold", idx), wb_data, v.wbd);
  endtask

  initial begin
    //                opc          f3      alu           rs2           rd  rw  rdata         dly mem addr          be       wdata         we exc wbd           wbrw
    vecs[0]  = '{7'b0110011, 3'b000, 32'h00000007, 32'h0,        5'd5, 1'b1, 32'h0,        0, 1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b0, 32'h00000007, 1'b1};
    vecs[1]  = '{7'b0000011, 3'b000, 32'h00000103, 32'h0,        5'd6, 1'b1, 32'h80FF1234, 2, 1'b1, 32'h00000100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 1'b1};
    vecs[2]  = '{7'b0000011, 3'b100, 32'h00000103, 32'h0,        5'd7, 1'b1, 32'h80FF1234, 2, 1'b1, 32'h00000100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h00000080, 1'b1};
    vecs[3]  = '{7'b0100011, 3'b001, 32'h00000206, 32'hDEADBEEF, 5'd8, 1'b1, 32'h0,        1, 1'b1, 32'h00000204, 4'b1100, 32'hBEEFBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{7'b0000011, 3'b010, 32'h00000102, 32'h0,        5'd9, 1'b1, 32'h0,        0, 1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[5]  = '{7'b0000011, 3'b001, 32'h00000102, 32'h0,        5'd10, 1'b1, 32'h80FF1234, 1, 1'b1, 32'h00000100, 4'b1111, 32'h0,       1'b0, 1'b0, 32'hFFFF80FF, 1'b1};
    vecs[6]  = '{7'b0000011, 3'b101, 32'h00000100, 32'h0,        5'd11, 1'b1, 32'h80FF8234, 1, 1'b1, 32'h00000100, 4'b1111, 32'h0,       1'b0, 1'b0, 32'h00008234, 1'b1};
    vecs[7]  = '{7'b0100011, 3'b000, 32'h00000001, 32'h000000A5, 5'd12, 1'b1, 32'h0,       1, 1'b1, 32'h00000000, 4'b0010, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{7'b0100011, 3'b010, 32'h00000010, 32'h12345678, 5'd13, 1'b1, 32'h0,       3, 1'b1, 32'h00000010, 4'b1111, 32'h12345678, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{7'b0000011, 3'b010, 32'h00000020, 32'h0,        5'd14, 1'b1, 32'hCAFEF00D, 1, 1'b1, 32'h00000020, 4'b1111, 32'h0,       1'b0, 1'b0, 32'hCAFEF00D, 1'b1};
    vecs[10] = '{7'b0000011, 3'b011, 32'h00000000, 32'h0,        5'd15, 1'b1, 32'h0,       0, 1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[11] = '{7'b0100011, 3'b011, 32'h00000000, 32'h1,        5'd16, 1'b1, 32'h0,       0, 1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[12] = '{7'b0100011, 3'b001, 32'h00000003, 32'h1,        5'd17, 1'b1, 32'h0,       0, 1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[13] = '{7'b0000011, 3'b000, 32'h00000101, 32'h0,        5'd18, 1'b1, 32'h80FF1234, 1, 1'b1, 32'h00000100, 4'b1111, 32'h0,       1'b0, 1'b0, 32'h00000012, 1'b1};
    vecs[14] = '{7'b0010011, 3'b000, 32'h0000ABCD, 32'h0,        5'd19, 1'b0, 32'h0,       0, 1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b0, 32'h0000ABCD, 1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst dmem_be", 32'(dmem_be), 32'd0);
    chk("rst dmem_wdata", dmem_wdata, 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst wb_exc", 32'(wb_exc), 32'd0);

    for (int i = 0; i < NumVec; i++) run_vec(i);

    // Reset while in REQ abandons the access; later ready in IDLE is ignored
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 7'b0000011;
    funct3   = 3'b010;
    aluout   = 32'h00000040;
    rd       = 5'd9;
    regwrite = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rstreq req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstreq dmem_req", 32'(dmem_req), 32'd0);
    chk("rstreq stall", 32'(stall), 32'd0);
    chk("rstreq wb_valid", 32'(wb_valid), 32'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11111111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstreq no_wb c%0d", k), 32'(wb_valid), 32'd0);
      chk($sformatf("idle_ready no_req c%0d", k), 32'(dmem_req), 32'd0);
    end
    dmem_ready = 1'b0;

    // sw then an ALU op held on the inputs under stall
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 7'b0100011;
    funct3   = 3'b010;
    aluout   = 32'h00000030;
    rs2data  = 32'h00000001;
    rd       = 5'd0;
    regwrite = 1'b0;
    @(posedge clk);
    #1;
    opcode   = 7'b0110011;
    funct3   = 3'b000;
    aluout   = 32'h00000055;
    rd       = 5'd3;
    regwrite = 1'b1;
    @(negedge clk);
    chk("b2b req", 32'(dmem_req), 32'd1);
    chk("b2b stall_ready_cycle", 32'(stall), 32'd1);
    chk("b2b we", 32'(dmem_we), 32'd1);
    dmem_ready = 1'b1;
    @(posedge clk);
    #1 dmem_ready = 1'b0;
    @(negedge clk);
    chk("b2b st wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b st wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("b2b st wb_data", wb_data, 32'd0);
    chk("b2b stall_released", 32'(stall), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b alu wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b alu wb_data", wb_data, 32'h00000055);
    chk("b2b alu wb_rd", 32'(wb_rd), 32'd3);
    chk("b2b alu wb_regwrite", 32'(wb_regwrite), 32'd1);
    chk("b2b alu no_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("b2b wb_valid_end", 32'(wb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
